// File: rtl/uart_rx_pkg.sv
// Constants and helpers shared by the UART Rx front end, control FSM and checkers.
package uart_rx_pkg;

  localparam int unsigned PRESCALE_W = 6;
  localparam int unsigned BIT_CNT_W  = 4;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  localparam int unsigned FRAME_BITS_NOPAR = 10;
  localparam int unsigned FRAME_BITS_PAR   = 11;

  // Half of the effective oversampling ratio; unsupported ratios fall back to 8.
  function automatic int unsigned half_prescale(input int unsigned prescale);
    int unsigned half;
    case (prescale)
      PRESCALE_16: half = PRESCALE_16 / 2;
      PRESCALE_32: half = PRESCALE_32 / 2;
      default:     half = PRESCALE_8 / 2;
    endcase
    return half;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_edge_sampler_if.sv
// Control/status bundle between the Rx control FSM (master) and the edge sampler (slave).
interface uart_rx_edge_sampler_if #(
  parameter int unsigned PRESCALE_W = uart_rx_pkg::PRESCALE_W,
  parameter int unsigned BIT_CNT_W  = uart_rx_pkg::BIT_CNT_W
);

  logic                  S_Data;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  count_EN;
  logic                  S_EN;
  logic [PRESCALE_W-1:0] edge_count;
  logic [BIT_CNT_W-1:0]  bit_count;
  logic                  sampled;
  logic                  sampled_bit;

  modport master (
    output S_Data, Prescale, count_EN, S_EN,
    input  edge_count, bit_count, sampled, sampled_bit
  );

  modport slave (
    input  S_Data, Prescale, count_EN, S_EN,
    output edge_count, bit_count, sampled, sampled_bit
  );

endinterface

// File: rtl/uart_rx_edge_counter.sv
// Edge-within-bit and completed-bit counters with prescale decode; bit count saturates.
module uart_rx_edge_counter #(
  parameter int unsigned PRESCALE_W = uart_rx_pkg::PRESCALE_W,
  parameter int unsigned BIT_CNT_W  = uart_rx_pkg::BIT_CNT_W
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  count_EN,
  output logic [PRESCALE_W-1:0] half_p,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic [BIT_CNT_W-1:0]  bit_count
);
  import uart_rx_pkg::*;

  logic [PRESCALE_W-1:0] edge_q;
  logic [BIT_CNT_W-1:0]  bit_q;
  logic [PRESCALE_W-1:0] last_edge;

  always_comb begin
    half_p    = PRESCALE_W'(half_prescale(int'(Prescale)));
    last_edge = (half_p << 1) - PRESCALE_W'(1);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else if (!count_EN) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else if (edge_q == last_edge) begin
      edge_q <= '0;
      if (bit_q != '1) begin
        bit_q <= bit_q + BIT_CNT_W'(1);
      end
    end else begin
      edge_q <= edge_q + PRESCALE_W'(1);
    end
  end

  assign edge_count = edge_q;
  assign bit_count  = bit_q;

endmodule

// File: rtl/uart_rx_edge_sampler.sv
// UART Rx timing front end: three mid-bit samples, majority vote, one-cycle strobe.
// Build option RX_SYNC_EN inserts a 2-flop synchronizer on S_Data.
module uart_rx_edge_sampler #(
  parameter int unsigned PRESCALE_W = uart_rx_pkg::PRESCALE_W,
  parameter int unsigned BIT_CNT_W  = uart_rx_pkg::BIT_CNT_W
) (
  input logic                   CLK,
  input logic                   Reset,
  uart_rx_edge_sampler_if.slave bus
);
  import uart_rx_pkg::*;

  logic [PRESCALE_W-1:0] half_p;
  logic [PRESCALE_W-1:0] edge_count;
  logic [BIT_CNT_W-1:0]  bit_count;
  logic                  line;

  uart_rx_edge_counter #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_counter (
    .CLK        (CLK),
    .Reset      (Reset),
    .Prescale   (bus.Prescale),
    .count_EN   (bus.count_EN),
    .half_p     (half_p),
    .edge_count (edge_count),
    .bit_count  (bit_count)
  );

`ifdef RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.S_Data};
    end
  end

  assign line = sync_q[1];
`else
  assign line = bus.S_Data;
`endif

  logic s0_q, s1_q, s2_q;
  logic armed_q;
  logic sampled_q, sampled_bit_q;
  logic cap_en, at_s0, at_s1, at_s2;
  logic s2_d;

  always_comb begin
    cap_en = bus.count_EN & bus.S_EN;
    at_s0  = (edge_count == half_p - PRESCALE_W'(2));
    at_s1  = (edge_count == half_p - PRESCALE_W'(1));
    at_s2  = (edge_count == half_p);
    s2_d   = (cap_en && at_s2) ? line : s2_q;
  end

  // armed_q tracks an unbroken S_EN window since the s0 capture of this bit.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      s0_q          <= 1'b1;
      s1_q          <= 1'b1;
      s2_q          <= 1'b1;
      armed_q       <= 1'b0;
      sampled_q     <= 1'b0;
      sampled_bit_q <= 1'b1;
    end else begin
      sampled_q <= 1'b0;
      s2_q      <= s2_d;
      if (!bus.count_EN) begin
        armed_q <= 1'b0;
      end else if (at_s0) begin
        armed_q <= bus.S_EN;
        if (bus.S_EN) begin
          s0_q <= line;
        end
      end else if (at_s1) begin
        armed_q <= armed_q & bus.S_EN;
        if (bus.S_EN) begin
          s1_q <= line;
        end
      end else if (at_s2) begin
        armed_q <= 1'b0;
        if (armed_q && bus.S_EN) begin
          sampled_q     <= 1'b1;
          sampled_bit_q <= majority3(s0_q, s1_q, s2_d);
        end
      end
    end
  end

  assign bus.edge_count  = edge_count;
  assign bus.bit_count   = bit_count;
  assign bus.sampled     = sampled_q & bus.count_EN;
  assign bus.sampled_bit = sampled_bit_q;

endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// Self-checking bench for uart_rx_edge_sampler against a per-bit-period reference model.
module tb_uart_rx_edge_sampler;
  localparam int unsigned PW   = 6;
  localparam int unsigned BW   = 4;
  localparam int          MaxN = 400;
`ifdef RX_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif

  logic CLK   = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  uart_rx_edge_sampler_if #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) bus ();

  uart_rx_edge_sampler #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  logic line_eff [MaxN];
  logic sen_arr  [MaxN];
  logic m_bit = 1'b1;

  // Reference model: k is the index of the rising edge since count_EN rose; values are
  // what the outputs read just after that edge.
  function automatic int exp_edge(input int k, input int p);
    return (k + 1) % p;
  endfunction

  function automatic int exp_bc(input int k, input int p);
    int b;
    b = (k + 1) / p;
    return (b > 15) ? 15 : b;
  endfunction

  function automatic logic exp_strobe(input int k, input int p);
    int h;
    h = p / 2;
    if (k % p != h) return 1'b0;
    return sen_arr[k-2] & sen_arr[k-1] & sen_arr[k];
  endfunction

  function automatic logic exp_vote(input int k);
    int ones;
    ones = int'(line_eff[k-2]) + int'(line_eff[k-1]) + int'(line_eff[k]);
    return (ones >= 2);
  endfunction

  // Drive the stimulus for edge j, leading S_Data by the synchronizer latency.
  task automatic drive_step(input int j, input int n, input logic cen);
    int idx;
    idx = j + Lat;
    bus.S_Data   = (idx >= 0 && idx < n) ? line_eff[idx] : 1'b1;
    bus.count_EN = cen;
    bus.S_EN     = (j >= 0 && j < n) ? sen_arr[j] : 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic preroll(input int n);
    for (int j = -Lat; j < 0; j++) drive_step(j, n, 1'b0);
  endtask

  task automatic idle(input int cycles);
    bus.S_Data   = 1'b1;
    bus.count_EN = 1'b0;
    bus.S_EN     = 1'b0;
    repeat (cycles) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic fill_frame(input logic [9:0] bits, input int p);
    for (int k = 0; k < MaxN; k++) begin
      line_eff[k] = (k / p < 10) ? bits[k/p] : 1'b1;
      sen_arr[k]  = 1'b1;
    end
  endtask

  task automatic test_reset();
    total++;
    if (bus.edge_count !== '0 || bus.bit_count !== '0 || bus.sampled !== 1'b0 ||
        bus.sampled_bit !== 1'b1) begin
      bad++;
      $display("FAIL reset_state got ec=%0d bc=%0d s=%b sb=%b want 0 0 0 1",
               bus.edge_count, bus.bit_count, bus.sampled, bus.sampled_bit);
    end
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    m_bit = 1'b1;
    idle(2);
  endtask

  task automatic test_frame();
    logic [9:0] frame;
    logic [9:0] want;
    logic [9:0] got;
    int nv;
    frame       = {1'b1, 8'h5A, 1'b0};
    want        = 10'b1010110100;  // bit i = i-th vote: 0,0,1,0,1,1,0,1,0,1
    got         = '0;
    nv          = 0;
    bus.Prescale = PW'(8);
    fill_frame(frame, 8);
    preroll(80);
    for (int k = 0; k < 80; k++) begin
      drive_step(k, 80, 1'b1);
      if (exp_strobe(k, 8)) m_bit = exp_vote(k);
      total++;
      if (bus.edge_count !== PW'(exp_edge(k, 8)) || bus.bit_count !== BW'(exp_bc(k, 8))) begin
        bad++;
        $display("FAIL frame_cnt k=%0d got ec=%0d bc=%0d want ec=%0d bc=%0d",
                 k, bus.edge_count, bus.bit_count, exp_edge(k, 8), exp_bc(k, 8));
      end
      total++;
      if (bus.sampled !== exp_strobe(k, 8) || bus.sampled_bit !== m_bit) begin
        bad++;
        $display("FAIL frame_vote k=%0d got s=%b sb=%b want s=%b sb=%b",
                 k, bus.sampled, bus.sampled_bit, exp_strobe(k, 8), m_bit);
      end
      if (bus.sampled === 1'b1) begin
        total++;
        if (bus.edge_count !== PW'(5)) begin
          bad++;
          $display("FAIL frame_strobe_pos got ec=%0d want 5", bus.edge_count);
        end
        if (nv < 10) got[nv] = bus.sampled_bit;
        nv++;
      end
    end
    total++;
    if (nv != 10 || got !== want) begin
      bad++;
      $display("FAIL frame_seq got n=%0d bits=%b want n=10 bits=%b", nv, got, want);
    end
    total++;
    if (bus.bit_count !== BW'(10)) begin
      bad++;
      $display("FAIL frame_end_bc got=%0d want=10", bus.bit_count);
    end
    idle(2);
  endtask

  task automatic test_glitch();
    bus.Prescale = PW'(16);
    for (int k = 0; k < MaxN; k++) begin
      line_eff[k] = (k == 7 || k == 23 || k == 24) ? 1'b1 : 1'b0;
      sen_arr[k]  = 1'b1;
    end
    preroll(32);
    for (int k = 0; k < 32; k++) begin
      drive_step(k, 32, 1'b1);
      if (exp_strobe(k, 16)) m_bit = exp_vote(k);
      total++;
      if (bus.sampled !== exp_strobe(k, 16) || bus.sampled_bit !== m_bit) begin
        bad++;
        $display("FAIL glitch k=%0d got s=%b sb=%b want s=%b sb=%b",
                 k, bus.sampled, bus.sampled_bit, exp_strobe(k, 16), m_bit);
      end
      if (k == 8 || k == 24) begin
        total++;
        if (bus.sampled !== 1'b1 || bus.sampled_bit !== (k == 24)) begin
          bad++;
          $display("FAIL glitch_vote k=%0d got s=%b sb=%b want s=1 sb=%b",
                   k, bus.sampled, bus.sampled_bit, (k == 24));
        end
      end
    end
    idle(2);
  endtask

  task automatic test_illegal_prescale();
    bus.Prescale = PW'(12);
    for (int k = 0; k < MaxN; k++) begin
      line_eff[k] = 1'($urandom_range(0, 1));
      sen_arr[k]  = 1'b1;
    end
    preroll(40);
    for (int k = 0; k < 40; k++) begin
      drive_step(k, 40, 1'b1);
      if (exp_strobe(k, 8)) m_bit = exp_vote(k);
      total++;
      if (bus.edge_count !== PW'(exp_edge(k, 8)) || bus.sampled !== exp_strobe(k, 8) ||
          bus.sampled_bit !== m_bit) begin
        bad++;
        $display("FAIL illegal_p k=%0d got ec=%0d s=%b sb=%b want ec=%0d s=%b sb=%b",
                 k, bus.edge_count, bus.sampled, bus.sampled_bit,
                 exp_edge(k, 8), exp_strobe(k, 8), m_bit);
      end
    end
    idle(2);
  endtask

  task automatic test_saturation();
    bus.Prescale = PW'(8);
    fill_frame(10'h3FF, 8);
    preroll(160);
    for (int k = 0; k < 160; k++) begin
      drive_step(k, 160, 1'b1);
      if (exp_strobe(k, 8)) m_bit = exp_vote(k);
      total++;
      if (bus.edge_count !== PW'(exp_edge(k, 8)) || bus.bit_count !== BW'(exp_bc(k, 8))) begin
        bad++;
        $display("FAIL saturate k=%0d got ec=%0d bc=%0d want ec=%0d bc=%0d",
                 k, bus.edge_count, bus.bit_count, exp_edge(k, 8), exp_bc(k, 8));
      end
    end
    total++;
    if (bus.bit_count !== BW'(15)) begin
      bad++;
      $display("FAIL saturate_end got bc=%0d want 15", bus.bit_count);
    end
    idle(2);
  endtask

  task automatic test_random();
    int ps [3];
    int p;
    int n;
    ps = '{8, 16, 32};
    for (int f = 0; f < 4; f++) begin
      p            = ps[$urandom_range(0, 2)];
      n            = 10 * p;
      bus.Prescale = PW'(p);
      for (int b = 0; b < 10; b++) begin
        logic v;
        v = 1'($urandom_range(0, 1));
        for (int e = 0; e < p; e++) begin
          line_eff[b*p+e] = v;
          sen_arr[b*p+e]  = 1'b1;
        end
        if ($urandom_range(0, 1) == 1) line_eff[b*p+$urandom_range(0, p-1)] = ~v;
        if ($urandom_range(0, 2) == 0) sen_arr[b*p+$urandom_range(p/2-3, p/2+1)] = 1'b0;
      end
      preroll(n);
      for (int k = 0; k < n; k++) begin
        drive_step(k, n, 1'b1);
        if (exp_strobe(k, p)) m_bit = exp_vote(k);
        total++;
        if (bus.edge_count !== PW'(exp_edge(k, p)) || bus.bit_count !== BW'(exp_bc(k, p)) ||
            bus.sampled !== exp_strobe(k, p) || bus.sampled_bit !== m_bit) begin
          bad++;
          $display("FAIL random p=%0d k=%0d got ec=%0d bc=%0d s=%b sb=%b want %0d %0d %b %b",
                   p, k, bus.edge_count, bus.bit_count, bus.sampled, bus.sampled_bit,
                   exp_edge(k, p), exp_bc(k, p), exp_strobe(k, p), m_bit);
        end
      end
      idle(2);
    end
  endtask

  task automatic test_abort();
    bus.Prescale = PW'(8);
    for (int k = 0; k < MaxN; k++) begin
      line_eff[k] = 1'($urandom_range(0, 1));
      sen_arr[k]  = 1'b1;
    end
    preroll(48);
    for (int k = 0; k < 35; k++) begin
      drive_step(k, 48, 1'b1);
      if (exp_strobe(k, 8)) m_bit = exp_vote(k);
      total++;
      if (bus.edge_count !== PW'(exp_edge(k, 8)) || bus.sampled !== exp_strobe(k, 8) ||
          bus.sampled_bit !== m_bit) begin
        bad++;
        $display("FAIL abort_pre k=%0d got ec=%0d s=%b sb=%b want ec=%0d s=%b sb=%b",
                 k, bus.edge_count, bus.sampled, bus.sampled_bit,
                 exp_edge(k, 8), exp_strobe(k, 8), m_bit);
      end
    end
    // edge_count now reads 3 in bit 4; drop count_EN and hold it low for a bit period.
    for (int k = 35; k < 44; k++) begin
      drive_step(k, 48, 1'b0);
      total++;
      if (bus.edge_count !== '0 || bus.bit_count !== '0 || bus.sampled !== 1'b0 ||
          bus.sampled_bit !== m_bit) begin
        bad++;
        $display("FAIL abort_drop k=%0d got ec=%0d bc=%0d s=%b sb=%b want 0 0 0 %b",
                 k, bus.edge_count, bus.bit_count, bus.sampled, bus.sampled_bit, m_bit);
      end
    end
    for (int k = 0; k < MaxN; k++) begin
      line_eff[k] = 1'b0;
      sen_arr[k]  = 1'b1;
    end
    preroll(16);
    for (int k = 0; k < 12; k++) begin
      drive_step(k, 16, 1'b1);
      if (exp_strobe(k, 8)) m_bit = exp_vote(k);
      total++;
      if (bus.sampled !== exp_strobe(k, 8) || bus.sampled_bit !== m_bit) begin
        bad++;
        $display("FAIL abort_frame2 k=%0d got s=%b sb=%b want s=%b sb=%b",
                 k, bus.sampled, bus.sampled_bit, exp_strobe(k, 8), m_bit);
      end
    end
    #2;
    Reset = 1'b1;
    #1;
    m_bit = 1'b1;
    total++;
    if (bus.edge_count !== '0 || bus.bit_count !== '0 || bus.sampled !== 1'b0 ||
        bus.sampled_bit !== 1'b1) begin
      bad++;
      $display("FAIL abort_reset got ec=%0d bc=%0d s=%b sb=%b want 0 0 0 1",
               bus.edge_count, bus.bit_count, bus.sampled, bus.sampled_bit);
    end
    idle(2);
    Reset = 1'b0;
    idle(3);
  endtask

  initial begin
    bus.S_Data   = 1'b1;
    bus.Prescale = PW'(8);
    bus.count_EN = 1'b0;
    bus.S_EN     = 1'b0;
    #12;
    test_reset();
    test_frame();
    test_glitch();
    test_illegal_prescale();
    test_saturation();
    test_random();
    test_abort();
    test_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
